// File: rtl/apb_txn_monitor.sv
// Passive APB monitor: records every completed transfer into a capture FIFO with a valid/ready drain port.
// Build with APB_MON_PROT_CHECK_EN defined to include the sticky protocol checker driving prot_err.

module apb_txn_monitor #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int WAIT_W     = 4,
  localparam int SLV_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [ADDR_W-1:0]  PADDR,
  input  logic [DATA_W-1:0]  PWDATA,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0] PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic               PREADY,
  input  logic               PSLVERR,
  input  logic               mon_en,
  input  logic               ovf_clr,
  output logic               txn_valid,
  input  logic               txn_ready,
  output logic [ADDR_W-1:0]  txn_addr,
  output logic [DATA_W-1:0]  txn_data,
  output logic               txn_write,
  output logic [SLV_W-1:0]   txn_slv,
  output logic               txn_err,
  output logic [WAIT_W-1:0]  txn_wait,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               overflow,
  output logic               prot_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              write;
    logic [SLV_W-1:0]  slv;
    logic              err;
    logic [WAIT_W-1:0] wcnt;
  } rec_t;

  state_t            state;
  state_t            phase;
  logic [WAIT_W-1:0] wait_cnt;
  logic [SLV_W-1:0]  slv_idx;
  logic              complete;
  rec_t              new_rec;
  rec_t              head;
  rec_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              pop;
  logic              push_req;
  logic              push;
  logic              ovf_evt;

  // The state register rests in IDLE between transfers; a setup cycle (including a
  // back-to-back one straight after a completion) is recognised the cycle PSEL is seen.
  always_comb begin
    phase = state;
    if (state == IDLE && |PSEL) phase = SETUP;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (phase)
        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (PREADY) state <= IDLE;
          else if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    slv_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (PSEL[i]) slv_idx = SLV_W'(i);
    end
  end

  always_comb begin
    complete      = (phase == ACCESS) && PENABLE && PREADY && (|PSEL);
    new_rec.addr  = PADDR;
    new_rec.data  = PWRITE ? PWDATA : PRDATA;
    new_rec.write = PWRITE;
    new_rec.slv   = slv_idx;
    new_rec.err   = PSLVERR;
    new_rec.wcnt  = wait_cnt;
  end

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  always_comb begin
    full     = (fifo_count == CNT_W'(FIFO_DEPTH));
    pop      = txn_valid && txn_ready;
    push_req = complete && mon_en;
    push     = push_req && (!full || pop);
    ovf_evt  = push_req && full && !pop;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (ovf_evt)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= new_rec;
  end

  // Record outputs read as zero whenever nothing is queued.
  assign txn_valid = (fifo_count != '0);
  assign head      = mem[rd_ptr];

  always_comb begin
    txn_addr  = '0;
    txn_data  = '0;
    txn_write = 1'b0;
    txn_slv   = '0;
    txn_err   = 1'b0;
    txn_wait  = '0;
    if (txn_valid) begin
      txn_addr  = head.addr;
      txn_data  = head.data;
      txn_write = head.write;
      txn_slv   = head.slv;
      txn_err   = head.err;
      txn_wait  = head.wcnt;
    end
  end

`ifdef APB_MON_PROT_CHECK_EN
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               pwrite_q;
  logic               in_wait;
  logic               viol;

  // in_wait marks that the previous cycle was a stalled access, so the bus must hold still.
  always_comb begin
    viol = ((phase == SETUP) && PENABLE)
        || ((phase == ACCESS) && !PENABLE)
        || ((PSEL & (PSEL - NUM_SLV'(1))) != '0)
        || ((phase == ACCESS) && in_wait &&
            ((PADDR != paddr_q) || (PWRITE != pwrite_q) ||
             (PSEL != psel_q) || (PWDATA != pwdata_q)));
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      psel_q   <= '0;
      pwrite_q <= 1'b0;
      in_wait  <= 1'b0;
      prot_err <= 1'b0;
    end else begin
      paddr_q  <= PADDR;
      pwdata_q <= PWDATA;
      psel_q   <= PSEL;
      pwrite_q <= PWRITE;
      in_wait  <= (phase == ACCESS) && !PREADY;
      if (viol) prot_err <= 1'b1;
    end
  end
`else
  assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_txn_monitor.sv
// Self-checking bench for apb_txn_monitor: directed and randomized APB transfers
// checked against a queue-based model of the capture FIFO.

module tb_apb_txn_monitor;

  localparam int DEPTH = 8;

  logic        PCLK;
  logic        PRESET;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic        PREADY;
  logic        PSLVERR;
  logic        mon_en;
  logic        ovf_clr;
  logic        txn_valid;
  logic        txn_ready;
  logic [31:0] txn_addr;
  logic [31:0] txn_data;
  logic        txn_write;
  logic [1:0]  txn_slv;
  logic        txn_err;
  logic [3:0]  txn_wait;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        prot_err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
    logic [1:0]  slv;
    logic        err;
    logic [3:0]  wt;
  } recT;

  recT  expQ[$];
  logic expOvf;
  logic protExp;
  int   nAsserts;
  int   nFails;

  apb_txn_monitor dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .mon_en(mon_en), .ovf_clr(ovf_clr), .txn_valid(txn_valid), .txn_ready(txn_ready),
    .txn_addr(txn_addr), .txn_data(txn_data), .txn_write(txn_write), .txn_slv(txn_slv),
    .txn_err(txn_err), .txn_wait(txn_wait), .fifo_count(fifo_count),
    .overflow(overflow), .prot_err(prot_err)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the drain port and status against the model's queue head.
  task automatic checkOutput(input string tag);
    checkEq({tag, " count"}, 64'(fifo_count), 64'(expQ.size()));
    checkEq({tag, " overflow"}, 64'(overflow), 64'(expOvf));
    checkEq({tag, " prot_err"}, 64'(prot_err), 64'(0));
    if (expQ.size() == 0) begin
      checkEq({tag, " valid"}, 64'(txn_valid), 64'(0));
    end else begin
      checkEq({tag, " valid"}, 64'(txn_valid), 64'(1));
      checkEq({tag, " addr"},  64'(txn_addr),  64'(expQ[0].addr));
      checkEq({tag, " data"},  64'(txn_data),  64'(expQ[0].data));
      checkEq({tag, " write"}, 64'(txn_write), 64'(expQ[0].write));
      checkEq({tag, " slv"},   64'(txn_slv),   64'(expQ[0].slv));
      checkEq({tag, " err"},   64'(txn_err),   64'(expQ[0].err));
      checkEq({tag, " wait"},  64'(txn_wait),  64'(expQ[0].wt));
    end
  endtask

  // Model of one completion edge: optional pop, then push or drop.
  task automatic modelComplete(input recT r, input logic rdy, input logic clr);
    bit dropped;
    dropped = 0;
    if (rdy && expQ.size() > 0) void'(expQ.pop_front());
    if (mon_en) begin
      if (expQ.size() < DEPTH) expQ.push_back(r);
      else dropped = 1;
    end
    if (dropped) expOvf = 1'b1;
    else if (clr) expOvf = 1'b0;
  endtask

  task automatic busIdle(input int n);
    repeat (n) begin
      @(negedge PCLK);
      PSEL = 4'b0000; PENABLE = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0;
      txn_ready = 1'b0; ovf_clr = 1'b0;
    end
  endtask

  // One APB transfer; returns at the start of its completion cycle, model already updated.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int slv, input logic wr,
                               input logic err, input int waits,
                               input logic readyAtEnd, input logic clrAtEnd);
    recT r;
    @(negedge PCLK);
    txn_ready = 1'b0; ovf_clr = 1'b0;
    PSEL = 4'(1 << slv); PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
    for (int w = 0; w <= waits; w++) begin
      @(negedge PCLK);
      PENABLE = 1'b1;
      PREADY  = (w == waits);
      PRDATA  = (w == waits) ? rdata : $urandom;
      PSLVERR = (w == waits) ? err : 1'($urandom);
    end
    txn_ready = readyAtEnd; ovf_clr = clrAtEnd;
    r.addr  = addr;
    r.data  = wr ? wdata : rdata;
    r.write = wr;
    r.slv   = 2'(slv);
    r.err   = err;
    r.wt    = (waits > 15) ? 4'd15 : 4'(waits);
    modelComplete(r, readyAtEnd, clrAtEnd);
  endtask

  task automatic randomXfer(input logic readyAtEnd, input logic clrAtEnd);
    applyStimulus($urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  readyAtEnd, clrAtEnd);
  endtask

  task automatic drainAll(input string tag);
    int guard;
    guard = 0;
    while (expQ.size() > 0 && guard < 2 * DEPTH) begin
      checkOutput(tag);
      txn_ready = 1'b1;
      @(negedge PCLK);
      void'(expQ.pop_front());
      guard++;
    end
    txn_ready = 1'b0;
    checkOutput({tag, " empty"});
  endtask

  task automatic pulseReset();
    @(negedge PCLK); PRESET = 1'b1;
    @(negedge PCLK); PRESET = 1'b0;
    expQ.delete();
    expOvf = 1'b0;
  endtask

  initial begin
    nAsserts = 0; nFails = 0; expOvf = 1'b0;
`ifdef APB_MON_PROT_CHECK_EN
    protExp = 1'b1;
`else
    protExp = 1'b0;
`endif
    PRESET = 1'b1; PADDR = '0; PWDATA = '0; PRDATA = '0; PSEL = '0; PENABLE = 1'b0;
    PWRITE = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0; mon_en = 1'b1; ovf_clr = 1'b0;
    txn_ready = 1'b0;

    repeat (2) @(negedge PCLK);
    checkEq("reset valid", 64'(txn_valid), 64'(0));
    checkEq("reset count", 64'(fifo_count), 64'(0));
    checkEq("reset overflow", 64'(overflow), 64'(0));
    checkEq("reset prot_err", 64'(prot_err), 64'(0));
    checkEq("reset addr", 64'(txn_addr), 64'(0));
    @(negedge PCLK); PRESET = 1'b0;

    $display("[TB] zero-wait write");
    applyStimulus(32'h1000, 32'hDEADBEEF, 32'h0, 1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    #1 checkEq("write early valid", 64'(txn_valid), 64'(0));
    busIdle(1);
    checkOutput("write");
    busIdle(1);
    checkOutput("write hold");
    drainAll("write drain");

    $display("[TB] read with waits and error");
    applyStimulus(32'h2040, 32'hAAAA5555, 32'h12345678, 3, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    busIdle(1);
    checkOutput("read");
    drainAll("read drain");

    $display("[TB] monitor disabled");
    mon_en = 1'b0;
    randomXfer(1'b0, 1'b0);
    busIdle(1);
    checkOutput("mon_en off");
    mon_en = 1'b1;
    randomXfer(1'b0, 1'b0);
    busIdle(1);
    checkOutput("mon_en on");
    drainAll("mon_en drain");

    $display("[TB] overflow with nine back-to-back transfers");
    for (int i = 0; i < 9; i++) randomXfer(1'b0, 1'b0);
    busIdle(1);
    checkEq("ovf count", 64'(fifo_count), 64'(8));
    checkEq("ovf flag", 64'(overflow), 64'(1));
    drainAll("ovf drain");
    @(negedge PCLK); ovf_clr = 1'b1;
    @(negedge PCLK); ovf_clr = 1'b0;
    expOvf = 1'b0;
    checkEq("ovf cleared", 64'(overflow), 64'(0));

    $display("[TB] full FIFO push with coincident pop");
    for (int i = 0; i < 8; i++) randomXfer(1'b0, 1'b0);
    randomXfer(1'b1, 1'b0);
    busIdle(1);
    checkEq("full pop count", 64'(fifo_count), 64'(8));
    checkEq("full pop ovf", 64'(overflow), 64'(0));
    checkOutput("full pop");
    randomXfer(1'b0, 1'b1);
    busIdle(1);
    checkEq("ovf beats clr", 64'(overflow), 64'(1));
    drainAll("full drain");
    pulseReset();

    $display("[TB] reset during access");
    randomXfer(1'b0, 1'b0);
    randomXfer(1'b0, 1'b0);
    busIdle(1);
    checkOutput("pre reset");
    @(negedge PCLK);
    PSEL = 4'b0100; PENABLE = 1'b0; PADDR = 32'h3000; PWRITE = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1; PREADY = 1'b0;
    @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    checkEq("async valid", 64'(txn_valid), 64'(0));
    checkEq("async count", 64'(fifo_count), 64'(0));
    checkEq("async addr", 64'(txn_addr), 64'(0));
    checkEq("async data", 64'(txn_data), 64'(0));
    expQ.delete();
    expOvf = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0; PSEL = 4'b0000; PENABLE = 1'b0; PREADY = 1'b1;
    busIdle(1);
    checkOutput("post reset");
    randomXfer(1'b0, 1'b0);
    busIdle(1);
    checkOutput("post reset xfer");
    drainAll("post reset drain");

    $display("[TB] randomized bursts");
    for (int b = 0; b < 4; b++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) randomXfer(1'b0, 1'b0);
      busIdle(1);
      checkOutput("burst");
      drainAll("burst drain");
    end

    $display("[TB] protocol checker");
    @(negedge PCLK);
    PSEL = 4'b0011; PENABLE = 1'b0; PREADY = 1'b1;
    busIdle(2);
    checkEq("prot multi psel", 64'(prot_err), 64'(protExp));
    pulseReset();
    checkEq("prot after reset", 64'(prot_err), 64'(0));
    @(negedge PCLK);
    PSEL = 4'b0001; PENABLE = 1'b0; PADDR = 32'h2000; PWRITE = 1'b1; PWDATA = 32'h55; PREADY = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1; PREADY = 1'b0;
    @(negedge PCLK);
    PADDR = 32'h2004;
    @(negedge PCLK);
    PREADY = 1'b1;
    busIdle(1);
    checkEq("prot addr change", 64'(prot_err), 64'(protExp));
    pulseReset();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
